// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser sitting on the read side of the UART async FIFO.
// Pops one character per frame, then shifts out start, data (LSB first),
// optional parity and 1..2 stop bits. Bit period = latched baud_div + 1 clocks.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 2,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  fifo_is_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BIT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  w_div_next;
  logic [DIV_WIDTH-1:0]  r_baud_cnt;
  logic [DIV_WIDTH-1:0]  w_baud_cnt_next;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [BIT_W-1:0]      w_bit_cnt_next;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [WAIT_W-1:0]     w_wait_cnt_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  r_parity;
  logic                  w_parity_next;
  logic                  r_txd;
  logic                  w_txd_next;
  logic                  r_fifo_r_en;
  logic                  r_busy;
  logic                  r_tx_done;
  logic                  w_tx_done_next;
  logic                  w_bit_end;

  // Parity over one character; odd parity is the inverse of the plain XOR.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
    return (^data) ^ PARITY_ODD;
  endfunction

  // The divisor is latched per frame, so mid-frame baud_div writes are ignored.
  assign w_bit_end = (r_baud_cnt == r_div);

  // Next-state, counter and serial-bit decode; defaults hold every register.
  always_comb begin
    w_state_next    = r_state;
    w_div_next      = r_div;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_wait_cnt_next = r_wait_cnt;
    w_shift_next    = r_shift;
    w_parity_next   = r_parity;
    w_tx_done_next  = 1'b0;
    w_txd_next      = 1'b1;

    case (r_state)
      S_IDLE: begin
        // Pop only when enabled and the FIFO really holds data: the FIFO
        // does not protect itself against a pop while empty.
        if (tx_en && !fifo_is_empty) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        w_state_next    = S_WAIT;
        w_wait_cnt_next = '0;
      end
      S_WAIT: begin
        if (r_wait_cnt == LAST_WAIT) begin
          w_state_next    = S_START;
          w_shift_next    = fifo_r_data;
          w_div_next      = baud_div;
          w_parity_next   = calc_parity(fifo_r_data);
          w_baud_cnt_next = '0;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next    = S_DATA;
          w_baud_cnt_next = '0;
          w_bit_cnt_next  = '0;
        end else begin
          w_baud_cnt_next = r_baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          w_shift_next    = {1'b0, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_next = '0;
            if (PARITY_EN) begin
              w_state_next = S_PARITY;
            end else begin
              w_state_next = S_STOP;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next    = S_STOP;
          w_baud_cnt_next = '0;
          w_bit_cnt_next  = '0;
        end else begin
          w_baud_cnt_next = r_baud_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          if (r_bit_cnt == LAST_STOP) begin
            w_state_next   = S_IDLE;
            w_bit_cnt_next = '0;
            w_tx_done_next = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Line level for the state being entered, so txd is a clean flop output.
    case (w_state_next)
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = w_shift_next[0];
      S_PARITY: w_txd_next = w_parity_next;
      default:  w_txd_next = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers: divisor, counters, shift register and parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
    end else begin
      r_div      <= w_div_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd       <= 1'b1;
      r_fifo_r_en <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_txd       <= w_txd_next;
      r_fifo_r_en <= (w_state_next == S_FETCH);
      r_busy      <= (w_state_next != S_IDLE);
      r_tx_done   <= w_tx_done_next;
    end
  end

  assign txd       = r_txd;
  assign fifo_r_en = r_fifo_r_en;
  assign busy      = r_busy;
  assign tx_done   = r_tx_done;

endmodule
